ram_port_arbiter: RTL and testbench
===================================

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 SHALL have parameter AWIDTH, default 3, RAM address width (depth = 2^AWIDTH).
REQ-002 SHALL have parameter DWIDTH, default 32, RAM data width.
REQ-003 SHALL have port clock, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports req0/req1, input, 1 each, requester access request.
REQ-006 SHALL have ports we0/we1, input, 1 each, request type (1 = write, 0 = read).
REQ-007 SHALL have ports addr0/addr1, input, AWIDTH each, request address.
REQ-008 SHALL have ports wdata0/wdata1, input, DWIDTH each, write data.
REQ-009 SHALL have ports lock0/lock1, input, 1 each, hold ownership for back-to-back accesses.
REQ-010 SHALL have ports gnt0/gnt1, output, 1 each, request accepted this cycle.
REQ-011 SHALL have ports rvalid0/rvalid1, output, 1 each, read data valid.
REQ-012 SHALL have ports rdata0/rdata1, output, DWIDTH each, read data.
REQ-013 SHALL have ports ram_addr (AWIDTH), ram_din (DWIDTH), ram_we (1), outputs to the single-port sync-read RAM.
REQ-014 SHALL have port ram_dout, input, DWIDTH, RAM read data (valid one cycle after address).

Function
REQ-015 SHALL issue at most one RAM access per cycle; gnt0 and gnt1 never both high.
REQ-016 SHALL assert gntN combinationally in the cycle reqN is accepted; the access executes at that rising edge.
REQ-017 SHALL drive ram_addr/ram_din/ram_we from the granted requester; ram_we = weN & gntN.
REQ-018 SHALL drive ram_addr=0, ram_din=0, ram_we=0 when no grant.
REQ-019 SHALL register rvalidN high exactly one cycle after a granted read by N (latency 1); low after granted writes.
REQ-020 SHALL drive rdataN = ram_dout when rvalidN high, else all zeros.
REQ-021 SHALL implement FSM states IDLE, OWN0, OWN1.
REQ-022 IDLE: single requester granted; both requesting resolved per REQ-029; grant with lockN high -> OWNN, else stay IDLE.
REQ-023 OWNN: only requester N may be granted; other requester's req ignored (gnt low).
REQ-024 OWNN -> IDLE when lockN low or reqN low in any cycle; that cycle still grants N if reqN high.
REQ-025 SHALL keep register last_gnt updated to the index of every granted requester.
REQ-026 Back-to-back reads (read then read, any address) SHALL produce rvalid on consecutive cycles without bubbles.
REQ-027 Write then read to same address on consecutive cycles SHALL return the newly written data.

Reset
REQ-028 reset_n low SHALL asynchronously force state=IDLE, rvalid0=rvalid1=0, rdata0=rdata1=0, last_gnt=1; gnt and ram_we SHALL be low while reset_n is low; a read granted in the cycle reset asserts produces no rvalid.

Configuration
REQ-029 Macro ARB_ROUND_ROBIN_EN: defined -> on IDLE contention grant the requester not equal to last_gnt; undefined -> fixed priority, requester 0 always wins contention (last_gnt still maintained).

Verification
REQ-030 Reset then req0 write addr=3 data=0xA5A5A5A5, then req0 read addr=3 -> gnt0 each cycle, rvalid0 next cycle, rdata0=0xA5A5A5A5.
REQ-031 req0 and req1 reads held high for 4 cycles, no lock, RR enabled -> grants 0,1,0,1; rvalids follow each by one cycle; disabled -> grants 0,0,0,0.
REQ-032 req0 with lock0 for 3 cycles while req1 high -> gnt0 for 3 cycles, gnt1 low; lock0 drops -> FSM IDLE, gnt1 next contention cycle (RR).
REQ-033 Write req1 addr=7 data=0x1 followed immediately by read req0 addr=7 -> rdata0=0x00000001 one cycle after read grant.
REQ-034 reset_n pulsed low during granted read by req1 -> rvalid1 stays 0, state IDLE, ram_we 0; next req0 granted first.
REQ-035 No requests for 5 cycles -> ram_we=0, ram_addr=0, gnt0=gnt1=0, rvalid0=rvalid1=0.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// -----------------------------------------------------------------------------
// ram_port_arbiter
//
// Shares one single-port, synchronous-read RAM between two requesters.
// At most one access is issued per cycle. The grant is combinational and the
// access executes at the next rising edge. Read data comes back one cycle
// after a granted read, on the requester's rvalid/rdata pair.
//
// A requester that is granted while holding its lock input keeps exclusive
// ownership of the RAM (OWN0/OWN1). It keeps ownership until it drops either
// lock or req. While one requester owns the RAM, the other requester's
// requests are ignored.
//
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   defined   : when both requesters contend in IDLE, the requester that was
//               not granted last wins.
//   undefined : fixed priority; requester 0 always wins contention.
//               last_gnt is still tracked.
//
// Parameters
//   AWIDTH      RAM address width (depth = 2**AWIDTH)
//   DWIDTH      RAM data width
//
// Ports
//   clock       rising-edge clock
//   reset_n     asynchronous active-low reset
//   reqN        access request from requester N
//   weN         1 = write, 0 = read
//   addrN       access address
//   wdataN      write data
//   lockN       hold ownership for back-to-back accesses
//   gntN        request accepted this cycle (combinational)
//   rvalidN     read data valid (one cycle after a granted read)
//   rdataN      read data; zero unless rvalidN is high
//   ram_addr    RAM address (zero when idle)
//   ram_din     RAM write data (zero when idle)
//   ram_we      RAM write enable
//   ram_dout    RAM read data, valid one cycle after the address
// -----------------------------------------------------------------------------
module ram_port_arbiter #(
    parameter int AWIDTH = 3,
    parameter int DWIDTH = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [AWIDTH-1:0] addr0,
    input  logic [AWIDTH-1:0] addr1,
    input  logic [DWIDTH-1:0] wdata0,
    input  logic [DWIDTH-1:0] wdata1,
    input  logic              lock0,
    input  logic              lock1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DWIDTH-1:0] rdata0,
    output logic [DWIDTH-1:0] rdata1,
    output logic [AWIDTH-1:0] ram_addr,
    output logic [DWIDTH-1:0] ram_din,
    output logic              ram_we,
    input  logic [DWIDTH-1:0] ram_dout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   last_gnt_q, last_gnt_d;
    logic   rvalid0_q, rvalid1_q;

    // Raw grant decision. It is not yet gated by reset.
    logic   grant0, grant1;

    // -------------------------------------------------------------------------
    // Grant decision and next state
    // -------------------------------------------------------------------------
    always_comb begin
        grant0  = 1'b0;
        grant1  = 1'b0;
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req0 && req1) begin
`ifdef ARB_ROUND_ROBIN_EN
                    // Alternate: the requester not granted last time wins.
                    grant0 = last_gnt_q;
                    grant1 = ~last_gnt_q;
`else
                    grant0 = 1'b1;
`endif
                end else begin
                    grant0 = req0;
                    grant1 = req1;
                end
                if (grant0 && lock0) begin
                    state_d = OWN0;
                end else if (grant1 && lock1) begin
                    state_d = OWN1;
                end
            end
            OWN0: begin
                // The other requester is ignored. The owner is still served
                // in the cycle it releases the lock.
                grant0 = req0;
                if (!(req0 && lock0)) begin
                    state_d = IDLE;
                end
            end
            OWN1: begin
                grant1 = req1;
                if (!(req1 && lock1)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        last_gnt_d = last_gnt_q;
        if (grant1) begin
            last_gnt_d = 1'b1;
        end else if (grant0) begin
            last_gnt_d = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            rvalid0_q  <= grant0 & ~we0;
            rvalid1_q  <= grant1 & ~we1;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // Grants are gated by reset. Otherwise a request seen while reset_n is
    // low could drive the RAM, because the FSM sits in IDLE during reset.
    assign gnt0 = grant0 & reset_n;
    assign gnt1 = grant1 & reset_n;

    assign ram_we   = (gnt0 & we0) | (gnt1 & we1);
    assign ram_addr = gnt0 ? addr0  : (gnt1 ? addr1  : '0);
    assign ram_din  = gnt0 ? wdata0 : (gnt1 ? wdata1 : '0);

    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata0  = rvalid0_q ? ram_dout : '0;
    assign rdata1  = rvalid1_q ? ram_dout : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ram_port_arbiter
//
// Self-checking bench for ram_port_arbiter (AWIDTH=3, DWIDTH=32).
//
// The bench does the following:
//   * Models the external synchronous-read RAM.
//   * Keeps a behavioural reference model of the arbitration rules:
//     owner, last winner and a shadow memory.
//   * Compares every DUT output against that model on every falling edge.
//   * Runs directed sequences with literal expectations, then randomized
//     traffic with occasional reset pulses.
// -----------------------------------------------------------------------------
module tb_ram_port_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic        we0 = 1'b0, we1 = 1'b0;
    logic [2:0]  addr0 = '0, addr1 = '0;
    logic [31:0] wdata0 = '0, wdata1 = '0;
    logic        lock0 = 1'b0, lock1 = 1'b0;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic [2:0]  ram_addr;
    logic [31:0] ram_din;
    logic        ram_we;
    logic [31:0] ram_dout;

    int n_chk = 0;
    int n_fail = 0;

    ram_port_arbiter #(.AWIDTH(3), .DWIDTH(32)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .req0    (req0),
        .req1    (req1),
        .we0     (we0),
        .we1     (we1),
        .addr0   (addr0),
        .addr1   (addr1),
        .wdata0  (wdata0),
        .wdata1  (wdata1),
        .lock0   (lock0),
        .lock1   (lock1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .rvalid0 (rvalid0),
        .rvalid1 (rvalid1),
        .rdata0  (rdata0),
        .rdata1  (rdata1),
        .ram_addr(ram_addr),
        .ram_din (ram_din),
        .ram_we  (ram_we),
        .ram_dout(ram_dout)
    );

    always #5 clock = ~clock;

    // External single-port RAM with a registered read (read-before-write).
    logic [31:0] ram [8];
    always @(posedge clock) begin
        if (ram_we) ram[ram_addr] <= ram_din;
        ram_dout <= ram[ram_addr];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // ---------------------------------------------------------------------
    // Reference model: the owner index (-1 = none), the last winner and a
    // shadow copy of memory.
    // ---------------------------------------------------------------------
    int          m_owner = -1;
    int          m_last  = 1;
    int          m_win, m_nxt;
    logic        m_rv0 = 1'b0, m_rv1 = 1'b0;
    logic [31:0] m_rd0 = '0, m_rd1 = '0;
    logic [31:0] m_mem [8];
    logic        own_req, own_lock, e_we;
    logic [2:0]  e_addr;
    logic [31:0] e_din;

    always @(negedge clock) begin
        if (!reset_n) begin
            chk("rst_gnt0", gnt0, 0);
            chk("rst_gnt1", gnt1, 0);
            chk("rst_ram_we", ram_we, 0);
            chk("rst_ram_addr", ram_addr, 0);
            chk("rst_rvalid0", rvalid0, 0);
            chk("rst_rvalid1", rvalid1, 0);
            chk("rst_rdata0", rdata0, 0);
            chk("rst_rdata1", rdata1, 0);
            m_owner = -1;
            m_last  = 1;
            m_rv0   = 1'b0;
            m_rv1   = 1'b0;
        end else begin
            if (m_owner >= 0) begin
                own_req  = (m_owner == 0) ? req0 : req1;
                own_lock = (m_owner == 0) ? lock0 : lock1;
                m_win = own_req ? m_owner : -1;
                m_nxt = (own_req && own_lock) ? m_owner : -1;
            end else begin
                if (req0 && req1)  m_win = RR ? ((m_last == 0) ? 1 : 0) : 0;
                else if (req0)     m_win = 0;
                else if (req1)     m_win = 1;
                else               m_win = -1;
                m_nxt = -1;
                if (m_win == 0 && lock0) m_nxt = 0;
                if (m_win == 1 && lock1) m_nxt = 1;
            end
            e_we = 1'b0; e_addr = '0; e_din = '0;
            if (m_win == 0) begin e_we = we0; e_addr = addr0; e_din = wdata0; end
            if (m_win == 1) begin e_we = we1; e_addr = addr1; e_din = wdata1; end

            chk("model_gnt0", gnt0, (m_win == 0));
            chk("model_gnt1", gnt1, (m_win == 1));
            chk("model_ram_we", ram_we, e_we);
            chk("model_ram_addr", ram_addr, e_addr);
            chk("model_ram_din", ram_din, e_din);
            chk("model_rvalid0", rvalid0, m_rv0);
            chk("model_rvalid1", rvalid1, m_rv1);
            chk("model_rdata0", rdata0, m_rv0 ? m_rd0 : 32'h0);
            chk("model_rdata1", rdata1, m_rv1 ? m_rd1 : 32'h0);

            m_rv0 = (m_win == 0) && !we0;
            m_rv1 = (m_win == 1) && !we1;
            if (m_rv0) m_rd0 = m_mem[addr0];
            if (m_rv1) m_rd1 = m_mem[addr1];
            if (e_we) m_mem[e_addr] = e_din;
            if (m_win >= 0) m_last = m_win;
            m_owner = m_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus helpers: inputs change 1 time unit after the rising edge.
    // ---------------------------------------------------------------------
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0; lock0 = 0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0; lock1 = 0;
    endtask

    task automatic set0(input bit r, input bit w, input logic [2:0] a, input logic [31:0] d, input bit l);
        req0 = r; we0 = w; addr0 = a; wdata0 = d; lock0 = l;
    endtask

    task automatic set1(input bit r, input bit w, input logic [2:0] a, input logic [31:0] d, input bit l);
        req1 = r; we1 = w; addr1 = a; wdata1 = d; lock1 = l;
    endtask

    task automatic do_reset();
        cyc(); idle(); reset_n = 0;
        cyc();
        cyc(); reset_n = 1;
    endtask

    int g;

    initial begin
        idle();
        reset_n = 0;
        cyc();
        cyc();
        reset_n = 1;

        // Fill the RAM with known data so that later reads are defined.
        for (int a = 0; a < 8; a++) begin
            cyc(); idle(); set0(1, 1, 3'(a), $urandom, 0);
        end

        // Write then read back the same address.
        do_reset();
        cyc(); idle(); set0(1, 1, 3, 32'hA5A5A5A5, 0); #2;
        chk("wr_gnt0", gnt0, 1);
        chk("wr_ram_we", ram_we, 1);
        chk("wr_ram_addr", ram_addr, 3);
        chk("wr_ram_din", ram_din, 32'hA5A5A5A5);
        cyc(); idle(); set0(1, 0, 3, 0, 0); #2;
        chk("rd_gnt0", gnt0, 1);
        chk("rd_ram_we", ram_we, 0);
        chk("wr_no_rvalid0", rvalid0, 0);
        cyc(); idle(); #2;
        chk("rd_rvalid0", rvalid0, 1);
        chk("rd_rdata0", rdata0, 32'hA5A5A5A5);

        // Contention for four cycles, with no lock.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(); idle(); set0(1, 0, 3'(i), 0, 0); set1(1, 0, 3'(i + 4), 0, 0); #2;
            chk("cont_gnt0", gnt0, RR ? ((i % 2) == 0) : 1'b1);
            chk("cont_gnt1", gnt1, RR ? ((i % 2) == 1) : 1'b0);
            if (i > 0) begin
                g = RR ? ((i - 1) % 2) : 0;
                chk("cont_rvalid0", rvalid0, (g == 0));
                chk("cont_rvalid1", rvalid1, (g == 1));
            end
        end
        cyc(); idle(); #2;
        chk("cont_last_rvalid0", rvalid0, RR ? 1'b0 : 1'b1);
        chk("cont_last_rvalid1", rvalid1, RR ? 1'b1 : 1'b0);

        // Locked ownership by requester 0 while requester 1 waits.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cyc(); idle(); set0(1, 0, 1, 0, 1); set1(1, 0, 2, 0, 0); #2;
            chk("lock_gnt0", gnt0, 1);
            chk("lock_gnt1", gnt1, 0);
        end
        cyc(); idle(); set1(1, 0, 2, 0, 0); #2;
        chk("release_gnt0", gnt0, 0);
        chk("release_gnt1", gnt1, 0);
        cyc(); idle(); set0(1, 0, 1, 0, 0); set1(1, 0, 2, 0, 0); #2;
        chk("after_lock_gnt0", gnt0, RR ? 1'b0 : 1'b1);
        chk("after_lock_gnt1", gnt1, RR ? 1'b1 : 1'b0);

        // Requester 1 writes, then requester 0 immediately reads the same address.
        cyc(); idle(); set1(1, 1, 7, 32'h1, 0); #2;
        chk("x_wr_gnt1", gnt1, 1);
        chk("x_wr_ram_we", ram_we, 1);
        cyc(); idle(); set0(1, 0, 7, 0, 0); #2;
        chk("x_rd_gnt0", gnt0, 1);
        cyc(); idle(); #2;
        chk("x_rd_rvalid0", rvalid0, 1);
        chk("x_rd_rdata0", rdata0, 32'h1);

        // Reset pulse during a granted read by requester 1.
        do_reset();
        cyc(); idle(); set1(1, 0, 2, 0, 0); #1;
        chk("rp_gnt1_before", gnt1, 1);
        reset_n = 0;
        set0(1, 1, 5, 32'hDEAD0000, 0); #1;
        chk("rp_gnt1_in_reset", gnt1, 0);
        chk("rp_ram_we_in_reset", ram_we, 0);
        cyc(); reset_n = 1; idle(); set0(1, 0, 0, 0, 0); set1(1, 0, 2, 0, 0); #2;
        chk("rp_rvalid1", rvalid1, 0);
        chk("rp_first_gnt0", gnt0, 1);
        chk("rp_first_gnt1", gnt1, 0);
        cyc(); idle(); #2;
        chk("rp_rvalid0_after", rvalid0, 1);
        chk("rp_rvalid1_after", rvalid1, 0);

        // No requests for five cycles.
        for (int i = 0; i < 5; i++) begin
            cyc(); idle(); #2;
            chk("quiet_gnt0", gnt0, 0);
            chk("quiet_gnt1", gnt1, 0);
            chk("quiet_ram_we", ram_we, 0);
            chk("quiet_ram_addr", ram_addr, 0);
            if (i > 0) begin
                chk("quiet_rvalid0", rvalid0, 0);
                chk("quiet_rvalid1", rvalid1, 0);
            end
        end

        // Randomized traffic, checked by the reference model on every cycle.
        for (int n = 0; n < 3000; n++) begin
            cyc();
            if (!reset_n) reset_n = 1;
            else if ($urandom_range(0, 149) == 0) reset_n = 0;
            set0($urandom_range(0, 9) < 7, $urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)),
                 $urandom, $urandom_range(0, 9) < 4);
            set1($urandom_range(0, 9) < 7, $urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)),
                 $urandom, $urandom_range(0, 9) < 4);
        end
        cyc(); idle();
        cyc();
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
